// File: rtl/display_scan_scheduler_pkg.sv
// Shared definitions for the seven-segment scan scheduler.
//   scan_state_t : scan controller states (IDLE, SHOW, BLANK)
//   BLANK_SEG    : all-ones cathode pattern (segments dark). It is wide enough
//                  to be sliced down to any digit width up to SEG_W_MAX.
//   ANODE_OFF    : all four active-low anodes disabled
//   anode_for()  : digit index -> active-low one-hot anode vector
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } scan_state_t;

  localparam int unsigned SEG_W_MAX = 64;
  localparam logic [SEG_W_MAX-1:0] BLANK_SEG = '1;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << idx;
    return ~onehot;
  endfunction

endpackage

// File: rtl/display_scan_scheduler_scan_timer.sv
// Loadable down-counter used to time the SHOW and BLANK phases.
//   clk, reset : system clock, synchronous active-high reset
//   load       : reload count with load_value (takes priority over counting)
//   load_value : value to reload; a phase of N cycles is loaded with N-1
//   tc         : terminal count, high while the count is zero
// The counter parks at zero, so it can never wrap.
module scan_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Each digit is lit for CLK_DIV cycles, followed by BLANK_CYCLES with all
// anodes off to suppress ghosting. New digit patterns are accepted into a
// pending buffer with a valid/ready handshake and copied into the displayed
// (shadow) buffer only at a frame boundary or while idle, so a frame is
// never shown half old / half new.
//   clk, reset      : system clock, synchronous active-high reset
//   enable          : scan enable; low blanks the display and idles the FSM
//   digit1..digit4  : offered segment patterns (digit1 = index 0)
//   load_valid      : new frame offered
//   load_ready      : pending buffer empty (combinational)
//   refreshcounter  : index of the current digit
//   anode           : active-low anode enables
//   seg_digit       : active-low cathode pattern of the lit digit
//   frame_done      : one-cycle pulse after the last cycle of each frame
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned DIGIT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [DIGIT_W-1:0] digit1,
  input  logic [DIGIT_W-1:0] digit2,
  input  logic [DIGIT_W-1:0] digit3,
  input  logic [DIGIT_W-1:0] digit4,
  input  logic               load_valid,
  output logic               load_ready,
  output logic [1:0]         refreshcounter,
  output logic [3:0]         anode,
  output logic [DIGIT_W-1:0] seg_digit,
  output logic               frame_done
);

  localparam int unsigned TMAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] SHOW_LOAD  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] BLANK_LOAD = (BLANK_CYCLES > 0) ? TW'(BLANK_CYCLES - 1) : '0;
  localparam bit HAS_BLANK = (BLANK_CYCLES != 0);
  localparam logic [DIGIT_W-1:0] SEG_OFF = BLANK_SEG[DIGIT_W-1:0];

  scan_state_t state_q, state_d;
  logic [1:0]  idx_q, idx_d;

  logic [DIGIT_W-1:0] pend   [0:3];
  logic [DIGIT_W-1:0] shadow [0:3];
  logic               pend_valid;

  logic               t_load;
  logic [TW-1:0]      t_value;
  logic               t_tc;

  logic               boundary;
  logic               commit;
  logic               accept;
  logic [3:0]         anode_d;
  logic [DIGIT_W-1:0] seg_d;

  scan_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (t_load),
    .load_value(t_value),
    .tc        (t_tc)
  );

  // Next state, next index and timer reload. The timer is reloaded on every
  // state entry, including SHOW->SHOW when blanking is disabled.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    t_load   = 1'b0;
    t_value  = '0;
    boundary = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      t_load  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SHOW;
          idx_d   = '0;
          t_load  = 1'b1;
          t_value = SHOW_LOAD;
        end
        SHOW: begin
          if (t_tc) begin
            t_load = 1'b1;
            if (HAS_BLANK) begin
              state_d = BLANK;
              t_value = BLANK_LOAD;
            end else begin
              boundary = (idx_q == 2'd3);
              idx_d    = idx_q + 2'd1;
              t_value  = SHOW_LOAD;
            end
          end
        end
        BLANK: begin
          if (t_tc) begin
            boundary = (idx_q == 2'd3);
            state_d  = SHOW;
            idx_d    = idx_q + 2'd1;
            t_load   = 1'b1;
            t_value  = SHOW_LOAD;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          t_load  = 1'b1;
        end
      endcase
    end
  end

  assign load_ready = ~pend_valid;
  assign accept     = load_valid && load_ready;
  // Commit needs pend_valid=1 and accept needs pend_valid=0, so the two
  // never act on the pending buffer in the same cycle.
  assign commit     = pend_valid && (boundary || (state_q == IDLE));

  // Registered outputs are derived from the next state. On a committing edge
  // the shadow buffer is being overwritten, so read the pending copy instead.
  always_comb begin
    anode_d = ANODE_OFF;
    seg_d   = SEG_OFF;
    if (state_d == SHOW) begin
      anode_d = anode_for(idx_d);
      seg_d   = commit ? pend[idx_d] : shadow[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      anode      <= ANODE_OFF;
      seg_digit  <= SEG_OFF;
      frame_done <= 1'b0;
      pend_valid <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        shadow[i] <= SEG_OFF;
        pend[i]   <= SEG_OFF;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      anode      <= anode_d;
      seg_digit  <= seg_d;
      frame_done <= boundary;
      if (commit) begin
        for (int unsigned i = 0; i < 4; i++) begin
          shadow[i] <= pend[i];
        end
        pend_valid <= 1'b0;
      end else if (accept) begin
        pend[0]    <= digit1;
        pend[1]    <= digit2;
        pend[2]    <= digit3;
        pend[3]    <= digit4;
        pend_valid <= 1'b1;
      end
    end
  end

  assign refreshcounter = idx_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_a, en_b;
  logic [7:0] d1, d2, d3, d4;
  logic       load_valid;

  logic       ready_a, fd_a;
  logic [1:0] rc_a;
  logic [3:0] an_a;
  logic [7:0] seg_a;

  logic       ready_b, fd_b;
  logic [1:0] rc_b;
  logic [3:0] an_b;
  logic [7:0] seg_b;

  int vecs = 0;
  int miscomp = 0;

  logic [31:0] pats_old;
  logic [31:0] pats_88;
  logic [31:0] pats_ff;
  logic [15:0] obs, expv;

  always #5 clk = ~clk;

  display_scan_scheduler #(
    .CLK_DIV(4),
    .BLANK_CYCLES(2),
    .DIGIT_W(8)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(en_a),
    .digit1(d1), .digit2(d2), .digit3(d3), .digit4(d4),
    .load_valid(load_valid), .load_ready(ready_a),
    .refreshcounter(rc_a), .anode(an_a), .seg_digit(seg_a), .frame_done(fd_a)
  );

  display_scan_scheduler #(
    .CLK_DIV(4),
    .BLANK_CYCLES(0),
    .DIGIT_W(8)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(en_b),
    .digit1(d1), .digit2(d2), .digit3(d3), .digit4(d4),
    .load_valid(load_valid), .load_ready(ready_b),
    .refreshcounter(rc_b), .anode(an_b), .seg_digit(seg_b), .frame_done(fd_b)
  );

  // Expected {anode, seg, refreshcounter, frame_done, load_ready} for cycle k
  // after scanning starts: 6-cycle digit slots (4 lit + 2 blank), 24-cycle frame.
  function automatic logic [15:0] exp_a(input int k, input logic [31:0] pats, input logic rdy);
    int d, w;
    logic [3:0] an;
    logic [7:0] seg;
    logic [1:0] rc;
    logic fd;
    d   = (k / 6) % 4;
    w   = k % 6;
    rc  = d[1:0];
    an  = (w < 4) ? ~(4'b0001 << d) : 4'hF;
    seg = (w < 4) ? pats[8*d +: 8] : 8'hFF;
    fd  = (k > 0) && (k % 24 == 0);
    return {an, seg, rc, fd, rdy};
  endfunction

  // No blanking: 4-cycle slots, 16-cycle frame, shadow still all-ones.
  function automatic logic [15:0] exp_b(input int k);
    int d;
    logic [1:0] rc;
    d  = (k / 4) % 4;
    rc = d[1:0];
    return {~(4'b0001 << d), 8'hFF, rc, ((k > 0) && (k % 16 == 0)), 1'b1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en_a = 1'b0; en_b = 1'b0; load_valid = 1'b0;
    d1 = '0; d2 = '0; d3 = '0; d4 = '0;
    step(); step();
    reset = 1'b0;
    obs = {an_a, seg_a, rc_a, fd_a, ready_a};
    expv = {4'hF, 8'hFF, 2'd0, 1'b0, 1'b1};
    vecs++;
    if (obs !== expv) begin
      miscomp++;
      $display("FAIL reset_a: got %h expected %h", obs, expv);
    end
    obs = {an_b, seg_b, rc_b, fd_b, ready_b};
    vecs++;
    if (obs !== expv) begin
      miscomp++;
      $display("FAIL reset_b: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_no_blank();
    en_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      obs = {an_b, seg_b, rc_b, fd_b, ready_b};
      expv = exp_b(k);
      vecs++;
      if (obs !== expv) begin
        miscomp++;
        $display("FAIL no_blank k=%0d: got %h expected %h", k, obs, expv);
      end
    end
    en_b = 1'b0;
    step();
  endtask

  task automatic test_scan();
    en_a = 1'b1;
    for (int k = 0; k < 48; k++) begin
      step();
      obs = {an_a, seg_a, rc_a, fd_a, ready_a};
      expv = exp_a(k, pats_ff, 1'b1);
      vecs++;
      if (obs !== expv) begin
        miscomp++;
        $display("FAIL scan k=%0d: got %h expected %h", k, obs, expv);
      end
    end
    en_a = 1'b0;
    step();
    obs = {an_a, seg_a, rc_a, fd_a, ready_a};
    expv = {4'hF, 8'hFF, 2'd0, 1'b0, 1'b1};
    vecs++;
    if (obs !== expv) begin
      miscomp++;
      $display("FAIL scan_disable: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_load_idle();
    d1 = 8'hC0; d2 = 8'hF9; d3 = 8'hA4; d4 = 8'hB0; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    vecs++;
    if (ready_a !== 1'b0) begin
      miscomp++;
      $display("FAIL idle_load_accept: load_ready got %b expected 0", ready_a);
    end
    step();
    obs = {an_a, seg_a, rc_a, fd_a, ready_a};
    expv = {4'hF, 8'hFF, 2'd0, 1'b0, 1'b1};
    vecs++;
    if (obs !== expv) begin
      miscomp++;
      $display("FAIL idle_load_commit: got %h expected %h", obs, expv);
    end
    en_a = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      obs = {an_a, seg_a, rc_a, fd_a, ready_a};
      expv = exp_a(k, pats_old, 1'b1);
      vecs++;
      if (obs !== expv) begin
        miscomp++;
        $display("FAIL idle_load_show k=%0d: got %h expected %h", k, obs, expv);
      end
    end
  endtask

  // Continues the frame sequence of test_load_idle (next observation is k=24).
  task automatic test_midframe_load();
    for (int k = 24; k < 72; k++) begin
      if (k == 31) begin
        d1 = 8'h88; d2 = 8'h88; d3 = 8'h88; d4 = 8'h88; load_valid = 1'b1;
      end else if (k == 32) begin
        d1 = 8'h00; d2 = 8'h00; d3 = 8'h00; d4 = 8'h00; load_valid = 1'b1;
      end else begin
        load_valid = 1'b0;
      end
      step();
      obs = {an_a, seg_a, rc_a, fd_a, ready_a};
      expv = exp_a(k, (k < 48) ? pats_old : pats_88, !((k >= 31) && (k < 48)));
      vecs++;
      if (obs !== expv) begin
        miscomp++;
        $display("FAIL midframe k=%0d: got %h expected %h", k, obs, expv);
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_enable_drop();
    for (int k = 72; k < 86; k++) begin
      step();
      obs = {an_a, seg_a, rc_a, fd_a, ready_a};
      expv = exp_a(k, pats_88, 1'b1);
      vecs++;
      if (obs !== expv) begin
        miscomp++;
        $display("FAIL pre_drop k=%0d: got %h expected %h", k, obs, expv);
      end
    end
    en_a = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      obs = {an_a, seg_a, rc_a, fd_a, ready_a};
      expv = {4'hF, 8'hFF, 2'd0, 1'b0, 1'b1};
      vecs++;
      if (obs !== expv) begin
        miscomp++;
        $display("FAIL drop j=%0d: got %h expected %h", j, obs, expv);
      end
    end
    en_a = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      obs = {an_a, seg_a, rc_a, fd_a, ready_a};
      expv = exp_a(k, pats_88, 1'b1);
      vecs++;
      if (obs !== expv) begin
        miscomp++;
        $display("FAIL reenable k=%0d: got %h expected %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_reset_midframe();
    d1 = 8'hAA; d2 = 8'hAA; d3 = 8'hAA; d4 = 8'hAA; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    vecs++;
    if (ready_a !== 1'b0) begin
      miscomp++;
      $display("FAIL midreset_accept: load_ready got %b expected 0", ready_a);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    obs = {an_a, seg_a, rc_a, fd_a, ready_a};
    expv = {4'hF, 8'hFF, 2'd0, 1'b0, 1'b1};
    vecs++;
    if (obs !== expv) begin
      miscomp++;
      $display("FAIL midreset_values: got %h expected %h", obs, expv);
    end
    for (int k = 0; k < 50; k++) begin
      step();
      obs = {an_a, seg_a, rc_a, fd_a, ready_a};
      expv = exp_a(k, pats_ff, 1'b1);
      vecs++;
      if (obs !== expv) begin
        miscomp++;
        $display("FAIL midreset_scan k=%0d: got %h expected %h", k, obs, expv);
      end
    end
  endtask

  initial begin
    pats_old = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
    pats_88  = {8'h88, 8'h88, 8'h88, 8'h88};
    pats_ff  = '1;
    test_reset();
    test_no_blank();
    test_scan();
    test_load_idle();
    test_midframe_load();
    test_enable_drop();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
    $finish;
  end

endmodule
